// File: rtl/disp_colour_adapt_pkg.sv
// Shared definitions for the display colour adapter: output mode encodings
// and the 2x2 Bayer ordered-dither matrix.
package disp_colour_adapt_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BLACK = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_SWAP  = 2'd3
  } mode_e;

  // Bayer matrix [[0,2],[3,1]] indexed [row][col].
  function automatic logic [1:0] bayer_thr(input logic row, input logic col);
    logic [1:0] thr;
    case ({row, col})
      2'b00:   thr = 2'd0;
      2'b01:   thr = 2'd2;
      2'b10:   thr = 2'd3;
      default: thr = 2'd1;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/disp_colour_adapt_chan.sv
// One colour channel: widen by MSB-first pattern repeat, pass, truncate, or
// ordered dither with saturation; holds the stage-2 output register.
module disp_colour_adapt_chan #(
  parameter int unsigned BPC_IN  = 5,
  parameter int unsigned BPC_OUT = 8,
  parameter int unsigned DITHER  = 1
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               de,
  input  logic [1:0]         t,
  input  logic [BPC_IN-1:0]  din,
  output logic [BPC_OUT-1:0] dout
);

  logic [BPC_OUT-1:0] adapt_c;
  logic [BPC_OUT-1:0] dout_d;
  logic [BPC_OUT-1:0] dout_q;
  logic               unused_ok;

  if (BPC_OUT > BPC_IN) begin : g_widen
    for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
      localparam int unsigned SRC = BPC_IN - 1 - (i % BPC_IN);
      assign adapt_c[BPC_OUT-1-i] = din[SRC];
    end
    assign unused_ok = ^t;
  end else if (BPC_OUT == BPC_IN) begin : g_equal
    assign adapt_c   = din;
    assign unused_ok = ^t;
  end else if (DITHER == 0) begin : g_trunc
    assign adapt_c   = din[BPC_IN-1 -: BPC_OUT];
    assign unused_ok = ^{t, din};
  end else begin : g_dither
    localparam int unsigned D = BPC_IN - BPC_OUT;
    logic [BPC_IN-1:0] thr_c;
    logic [BPC_IN:0]   sum_c;

    // Threshold scaled so its range spans one discarded LSB step.
    if (D >= 2) begin : g_shl
      assign thr_c = BPC_IN'(t) << (D - 2);
    end else begin : g_half
      assign thr_c = BPC_IN'(t[1]);
    end

    always_comb begin
      sum_c   = {1'b0, din} + {1'b0, thr_c};
      adapt_c = sum_c[BPC_IN] ? '1 : sum_c[BPC_IN-1 -: BPC_OUT];
    end
    assign unused_ok = ^sum_c[D-1:0];
  end

  always_comb begin
    dout_d = de ? adapt_c : '0;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) dout_q <= '0;
    else         dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/disp_colour_adapt.sv
// Pixel output stage: frame-synchronous mode select, RGB width adaptation
// with optional ordered dither, syncs and colour aligned at 2-cycle latency.
module disp_colour_adapt
  import disp_colour_adapt_pkg::*;
#(
  parameter int unsigned         BPC_IN    = 5,
  parameter int unsigned         BPC_OUT   = 8,
  parameter int unsigned         DITHER    = 1,
  parameter logic [3*BPC_IN-1:0] FILL_COLR = 'h0886
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic [1:0]         mode,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_de,
  input  logic [BPC_IN-1:0]  in_r,
  input  logic [BPC_IN-1:0]  in_g,
  input  logic [BPC_IN-1:0]  in_b,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [BPC_OUT-1:0] out_r,
  output logic [BPC_OUT-1:0] out_g,
  output logic [BPC_OUT-1:0] out_b
);

  logic              hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic [BPC_IN-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [1:0]        t1_q, t1_d;
  logic              xp_q, xp_d, yp_q, yp_d, frame_q, frame_d;
  mode_e             mode_act_q, mode_act_d;
  logic              vs_rise_c, de_fall_c;

  // Stage 1: edge detect, position/frame tracking, mode select, threshold.
  always_comb begin
    vs_rise_c  = in_vsync & ~vs1_q;
    de_fall_c  = ~in_de & de1_q;

    mode_act_d = vs_rise_c ? mode_e'(mode) : mode_act_q;
    xp_d       = de_fall_c ? 1'b0 : (xp_q ^ in_de);
    yp_d       = vs_rise_c ? 1'b0 : (yp_q ^ de_fall_c);
    frame_d    = frame_q ^ vs_rise_c;

    // Threshold follows the pixel's own position, so it is taken before update.
    t1_d  = bayer_thr(yp_q ^ frame_q, xp_q);
    hs1_d = in_hsync;
    vs1_d = in_vsync;
    de1_d = in_de;

    r1_d = in_r;
    g1_d = in_g;
    b1_d = in_b;
    case (mode_act_q)
      MODE_BLACK: begin
        r1_d = '0;
        g1_d = '0;
        b1_d = '0;
      end
      MODE_FILL: begin
        r1_d = FILL_COLR[3*BPC_IN-1 -: BPC_IN];
        g1_d = FILL_COLR[2*BPC_IN-1 -: BPC_IN];
        b1_d = FILL_COLR[BPC_IN-1:0];
      end
      MODE_SWAP: begin
        r1_d = in_b;
        b1_d = in_r;
      end
      default: ;
    endcase

    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      r1_q       <= '0;
      g1_q       <= '0;
      b1_q       <= '0;
      t1_q       <= '0;
      xp_q       <= 1'b0;
      yp_q       <= 1'b0;
      frame_q    <= 1'b0;
      mode_act_q <= MODE_PASS;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      de2_q      <= 1'b0;
    end else begin
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      de1_q      <= de1_d;
      r1_q       <= r1_d;
      g1_q       <= g1_d;
      b1_q       <= b1_d;
      t1_q       <= t1_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      frame_q    <= frame_d;
      mode_act_q <= mode_act_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      de2_q      <= de2_d;
    end
  end

  // Stage 2: per-channel width adaptation and output register.
  disp_colour_adapt_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_r (
    .clk_pix (clk_pix), .rst_pix (rst_pix), .de (de1_q), .t (t1_q), .din (r1_q), .dout (out_r)
  );
  disp_colour_adapt_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_g (
    .clk_pix (clk_pix), .rst_pix (rst_pix), .de (de1_q), .t (t1_q), .din (g1_q), .dout (out_g)
  );
  disp_colour_adapt_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_b (
    .clk_pix (clk_pix), .rst_pix (rst_pix), .de (de1_q), .t (t1_q), .din (b1_q), .dout (out_b)
  );

  assign out_hsync = hs2_q;
  assign out_vsync = vs2_q;
  assign out_de    = de2_q;

endmodule

// File: tb/tb_disp_colour_adapt.sv
// Bench for disp_colour_adapt: three instances (5->8 widen, 8->5 truncate,
// 8->5 dither) against a counter-based reference model plus literal vectors.
module tb_disp_colour_adapt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [4:0] in5_r = '0, in5_g = '0, in5_b = '0;
  logic [7:0] in8_r = '0, in8_g = '0, in8_b = '0;

  logic       w_hs, w_vs, w_de, t_hs, t_vs, t_de, d_hs, d_vs, d_de;
  logic [7:0] w_r, w_g, w_b;
  logic [4:0] t_r, t_g, t_b, d_r, d_g, d_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .DITHER(1)) u_w (
    .clk_pix(clk), .rst_pix(rst), .mode(mode), .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de),
    .in_r(in5_r), .in_g(in5_g), .in_b(in5_b), .out_hsync(w_hs), .out_vsync(w_vs), .out_de(w_de),
    .out_r(w_r), .out_g(w_g), .out_b(w_b));
  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(0)) u_t (
    .clk_pix(clk), .rst_pix(rst), .mode(mode), .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de),
    .in_r(in8_r), .in_g(in8_g), .in_b(in8_b), .out_hsync(t_hs), .out_vsync(t_vs), .out_de(t_de),
    .out_r(t_r), .out_g(t_g), .out_b(t_b));
  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(1)) u_d (
    .clk_pix(clk), .rst_pix(rst), .mode(mode), .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de),
    .in_r(in8_r), .in_g(in8_g), .in_b(in8_b), .out_hsync(d_hs), .out_vsync(d_vs), .out_de(d_de),
    .out_r(d_r), .out_g(d_g), .out_b(d_b));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int hs, vs, de;
    int wr, wg, wb, tr, tg, tb, dr, dg, db;
  } exp_t;

  exp_t s1, s2, e;
  int   xcnt, ycnt, fcnt, mact, pde, pvs;
  int   bay [2][2] = '{'{0, 2}, '{3, 1}};

  function automatic int wid(input int v);
    return ((v << 10) | (v << 5) | v) >> 7;
  endfunction
  function automatic int trn(input int v);
    return v / 8;
  endfunction
  function automatic int dth(input int v, input int b);
    int s;
    s = v + 2 * b;
    return (s > 255) ? 31 : s / 8;
  endfunction

  function automatic exp_t zero_rec();
    exp_t z;
    z = '{default: 0};
    return z;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = zero_rec(); s2 = zero_rec();
      xcnt = 0; ycnt = 0; fcnt = 0; mact = 0; pde = 0; pvs = 0;
    end else begin
      int c5r, c5g, c5b, c8r, c8g, c8b, b;
      c5r = int'(in5_r); c5g = int'(in5_g); c5b = int'(in5_b);
      c8r = int'(in8_r); c8g = int'(in8_g); c8b = int'(in8_b);
      case (mact)
        1: begin c5r = 0; c5g = 0; c5b = 0; c8r = 0; c8g = 0; c8b = 0; end
        2: begin c5r = 2; c5g = 4; c5b = 6; c8r = 'h00; c8g = 'h08; c8b = 'h86; end
        3: begin c5r = int'(in5_b); c5b = int'(in5_r); c8r = int'(in8_b); c8b = int'(in8_r); end
        default: ;
      endcase
      b = bay[(ycnt + fcnt) % 2][xcnt % 2];
      e = zero_rec();
      e.hs = int'(in_hs); e.vs = int'(in_vs); e.de = int'(in_de);
      if (in_de) begin
        e.wr = wid(c5r); e.wg = wid(c5g); e.wb = wid(c5b);
        e.tr = trn(c8r); e.tg = trn(c8g); e.tb = trn(c8b);
        e.dr = dth(c8r, b); e.dg = dth(c8g, b); e.db = dth(c8b, b);
      end
      s2 = s1;
      s1 = e;
      if (in_vs && pvs == 0) begin
        fcnt++; ycnt = 0; mact = int'(mode);
      end else if (!in_de && pde == 1) begin
        ycnt++;
      end
      if (in_de) xcnt++;
      else if (pde == 1) xcnt = 0;
      pde = int'(in_de);
      pvs = int'(in_vs);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_w_hs", int'(w_hs), s2.hs); chk("m_w_vs", int'(w_vs), s2.vs); chk("m_w_de", int'(w_de), s2.de);
      chk("m_w_r", int'(w_r), s2.wr);   chk("m_w_g", int'(w_g), s2.wg);   chk("m_w_b", int'(w_b), s2.wb);
      chk("m_t_hs", int'(t_hs), s2.hs); chk("m_t_de", int'(t_de), s2.de); chk("m_t_vs", int'(t_vs), s2.vs);
      chk("m_t_r", int'(t_r), s2.tr);   chk("m_t_g", int'(t_g), s2.tg);   chk("m_t_b", int'(t_b), s2.tb);
      chk("m_d_hs", int'(d_hs), s2.hs); chk("m_d_de", int'(d_de), s2.de); chk("m_d_vs", int'(d_vs), s2.vs);
      chk("m_d_r", int'(d_r), s2.dr);   chk("m_d_g", int'(d_g), s2.dg);   chk("m_d_b", int'(d_b), s2.db);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit hs, input bit vs, input bit de,
                     input logic [4:0] r5, input logic [4:0] g5, input logic [4:0] b5,
                     input logic [7:0] r8, input logic [7:0] g8, input logic [7:0] b8);
    in_hs = hs; in_vs = vs; in_de = de;
    in5_r = r5; in5_g = g5; in5_b = b5;
    in8_r = r8; in8_g = g8; in8_b = b8;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hpulse();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
  endtask

  task automatic vpulse(input logic [1:0] m);
    mode = m;
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_w_r", int'(w_r), 0); chk("rst_w_de", int'(w_de), 0); chk("rst_d_g", int'(d_g), 0);
    rst = 1'b0;
    idle(2);

    // Frame 0 line 0: widen, truncate and dither row 0 side by side.
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hs_lat", int'(w_hs), 1);
    idle(1);
    drv(0, 0, 1, 5'h1F, 5'h10, 5'h00, 8'h87, 8'h84, 8'hFF);
    drv(0, 0, 1, 5'h10, 5'h10, 5'h00, 8'hFF, 8'h84, 8'hFF);
    chk("wid_1F", int'(w_r), 'hFF); chk("wid_de", int'(w_de), 1); chk("wid_g10", int'(w_g), 'h84);
    chk("wid_b00", int'(w_b), 'h00); chk("trn_87", int'(t_r), 'h10);
    chk("dth_r0x0", int'(d_g), 'h10); chk("dth_sat", int'(d_b), 'h1F); chk("pix_hs0", int'(w_hs), 0);
    drv(0, 0, 1, 5'h00, 5'h10, 5'h00, 8'h07, 8'h84, 8'hFF);
    chk("wid_10", int'(w_r), 'h84); chk("trn_FF", int'(t_r), 'h1F); chk("dth_r0x1", int'(d_g), 'h11);
    drv(0, 0, 1, 5'h1F, 5'h10, 5'h00, 8'h84, 8'h84, 8'hFF);
    chk("wid_00", int'(w_r), 'h00); chk("trn_07", int'(t_r), 'h00); chk("dth_r0x2", int'(d_g), 'h10);
    idle(1);
    chk("dth_r0x3", int'(d_g), 'h11);
    idle(2);

    // Line 1: Bayer row 1.
    hpulse();
    drv(0, 0, 1, 0, 0, 0, 8'h84, 8'h84, 8'h84);
    drv(0, 0, 1, 0, 0, 0, 8'h84, 8'h84, 8'h84);
    chk("dth_r1x0", int'(d_g), 'h11);
    idle(1);
    chk("dth_r1x1", int'(d_g), 'h10);
    idle(2);

    // New frame: row phase inverts.
    vpulse(2'd0);
    hpulse();
    drv(0, 0, 1, 0, 0, 0, 8'h84, 8'h84, 8'h84);
    drv(0, 0, 1, 0, 0, 0, 8'h84, 8'h84, 8'h84);
    chk("dth_f1x0", int'(d_g), 'h11);
    idle(1);
    chk("dth_f1x1", int'(d_g), 'h10);
    idle(2);

    // Mid-frame mode change to black must wait for the next vsync.
    mode = 2'd1;
    hpulse();
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    chk("blk_pend", int'(w_r), 'hFF);
    idle(3);
    vpulse(2'd1);
    hpulse();
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    chk("blk_r", int'(w_r), 0); chk("blk_de", int'(w_de), 1);
    idle(3);

    // Swap captured in the same cycle vsync rises.
    vpulse(2'd3);
    hpulse();
    drv(0, 0, 1, 5'h1F, 5'h00, 5'h00, 8'hFF, 8'h00, 8'h00);
    drv(0, 0, 1, 5'h1F, 5'h00, 5'h00, 8'hFF, 8'h00, 8'h00);
    chk("swp_r", int'(w_r), 'h00); chk("swp_b", int'(w_b), 'hFF); chk("swp_tb", int'(t_b), 'h1F);
    idle(3);

    // Solid fill colour through the widen path.
    vpulse(2'd2);
    hpulse();
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(0, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    chk("fil_r", int'(w_r), 'h10); chk("fil_g", int'(w_g), 'h21); chk("fil_b", int'(w_b), 'h31);
    chk("fil_tb", int'(t_b), 'h10);
    idle(3);

    // Blanking with live colour: colour forced to 0, syncs still delayed.
    drv(1, 0, 0, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(0, 0, 0, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    chk("blank_r", int'(w_r), 0); chk("blank_hs", int'(w_hs), 1);
    drv(0, 0, 0, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    chk("blank_hs0", int'(w_hs), 0); chk("blank_dr", int'(d_r), 0);

    // Asynchronous reset mid-line while fill mode is active.
    drv(1, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(1, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    drv(1, 0, 1, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_r", int'(w_r), 0); chk("arst_de", int'(w_de), 0);
    chk("arst_hs", int'(w_hs), 0); chk("arst_dg", int'(d_g), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 1, 5'h1F, 5'h00, 5'h00, 8'hFF, 8'h00, 8'h00);
    chk("post_early", int'(w_de), 0);
    idle(1);
    chk("post_r", int'(w_r), 'hFF); chk("post_b", int'(w_b), 'h00); chk("post_de", int'(w_de), 1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
